l2_instruction_responder: RTL and testbench

//  L2-side responder for the I-cache miss interface. Accepts a word address on the ADDRESS_TO_L2_*_INS

---
 rtl/l2_instruction_responder_pkg.sv | 15 +
 rtl/l2_line_assembler.sv | 22 ++
 rtl/l2_instruction_responder.sv | 111 +++++++++++
 tb/tb_l2_instruction_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/l2_instruction_responder_pkg.sv
// Shared constants and state encoding for the L2 instruction-side responder.
package l2_instruction_responder_pkg;
  localparam int ADDRESS_WIDTH_DEF  = 32;
  localparam int L2_BUS_WIDTH_DEF   = 512;
  localparam int MEM_DATA_WIDTH_DEF = 32;
  localparam int BEATS = L2_BUS_WIDTH_DEF / MEM_DATA_WIDTH_DEF;
  localparam int OFF_W = $clog2(BEATS);
  localparam int TAG_W = ADDRESS_WIDTH_DEF - 2 - OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/l2_line_assembler.sv
// Line buffer: one beat written per cycle at an index, whole line read flat.
module l2_line_assembler #(
  parameter int BEATS  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(BEATS)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [BEATS*DATA_W-1:0] line
);
  logic [BEATS-1:0][DATA_W-1:0] words;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     words <= '0;
    else if (wr_en) words[wr_idx] <= wr_data;
  end

  assign line = words;
endmodule

// File: rtl/l2_instruction_responder.sv
// I-cache miss responder: fetches a line from memory in beats, returns it, and
// keeps the last line so a repeat request is answered without memory traffic.
module l2_instruction_responder
  import l2_instruction_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int L2_BUS_WIDTH   = L2_BUS_WIDTH_DEF,
  parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
  output logic                     MEM_RD_VALID,
  input  logic                     MEM_RD_READY,
  output logic [ADDRESS_WIDTH-3:0] MEM_RD_ADDRESS,
  input  logic                     MEM_DATA_VALID,
  input  logic [MEM_DATA_WIDTH-1:0] MEM_DATA,
  input  logic                     INVALIDATE,
  output logic                     BUSY
);
  localparam int NB = L2_BUS_WIDTH / MEM_DATA_WIDTH;
  localparam int OW = $clog2(NB);
  localparam int TW = ADDRESS_WIDTH - 2 - OW;
  localparam logic [31:0] NB_V = NB;
  localparam logic [OW:0] CNT_FULL = NB_V[OW:0];
  localparam logic [OW:0] CNT_LAST = CNT_FULL - 1'b1;

  state_t        state, state_nxt;
  logic [OW:0]   issue_cnt, rsp_cnt;
  logic [TW-1:0] tag, req_tag;
  logic          line_valid, inv_seen, protocol_error;
  logic          accept, hit, rd_fire, beat_ok, last_beat;

  assign req_tag   = ADDRESS_TO_L2_INS[ADDRESS_WIDTH-3:OW];
  assign accept    = ADDRESS_TO_L2_VALID_INS && (state == IDLE);
  // An invalidate coinciding with the request must not be beaten by a stale hit.
  assign hit       = line_valid && (tag == req_tag) && !INVALIDATE;
  assign rd_fire   = MEM_RD_VALID && MEM_RD_READY;
  assign beat_ok   = MEM_DATA_VALID && (state == FILL) && (rsp_cnt < issue_cnt);
  assign last_beat = beat_ok && (rsp_cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = hit ? RESP : FILL;
      FILL:    if (last_beat) state_nxt = RESP;
      RESP:    if (DATA_FROM_L2_READY_INS) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ADDRESS_TO_L2_READY_INS = (state == IDLE);
    DATA_FROM_L2_VALID_INS  = (state == RESP);
    MEM_RD_VALID            = (state == FILL) && (issue_cnt < CNT_FULL);
    MEM_RD_ADDRESS          = {tag, issue_cnt[OW-1:0]};
    BUSY                    = (state != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      issue_cnt      <= '0;
      rsp_cnt        <= '0;
      tag            <= '0;
      line_valid     <= 1'b0;
      inv_seen       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (accept) tag <= req_tag;
      if (accept && !hit) begin
        issue_cnt <= '0;
        rsp_cnt   <= '0;
      end else begin
        if (rd_fire) issue_cnt <= issue_cnt + 1'b1;
        if (beat_ok) rsp_cnt   <= rsp_cnt + 1'b1;
      end
      // A line invalidated while in flight is still returned once, never retained.
      if (INVALIDATE)                   line_valid <= 1'b0;
      else if (last_beat && !inv_seen)  line_valid <= 1'b1;
      else if (accept && !hit)          line_valid <= 1'b0;
      if (INVALIDATE && state != IDLE)  inv_seen <= 1'b1;
      else if (accept && !hit)          inv_seen <= 1'b0;
      if (MEM_DATA_VALID && !beat_ok)   protocol_error <= 1'b1;
    end
  end

  l2_line_assembler #(
    .BEATS (NB),
    .DATA_W(MEM_DATA_WIDTH),
    .IDX_W (OW)
  ) u_asm (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .wr_en  (beat_ok),
    .wr_idx (rsp_cnt[OW-1:0]),
    .wr_data(MEM_DATA),
    .line   (DATA_FROM_L2_INS)
  );

  no_protocol_error: assert property (@(posedge CLK) disable iff (!RST_N) !protocol_error);
endmodule

// File: tb/tb_l2_instruction_responder.sv
// Directed bench: table of line requests against an in-order memory model, plus reset-mid-fill sequence.
module tb_l2_instruction_responder;
  logic         CLK = 0, RST_N = 0;
  logic         ADDRESS_TO_L2_VALID_INS = 0, ADDRESS_TO_L2_READY_INS;
  logic [29:0]  ADDRESS_TO_L2_INS = '0;
  logic         DATA_FROM_L2_VALID_INS, DATA_FROM_L2_READY_INS = 0;
  logic [511:0] DATA_FROM_L2_INS;
  logic         MEM_RD_VALID, MEM_RD_READY = 0;
  logic [29:0]  MEM_RD_ADDRESS;
  logic         MEM_DATA_VALID = 0;
  logic [31:0]  MEM_DATA = '0;
  logic         INVALIDATE = 0, BUSY;

  l2_instruction_responder dut (
    .CLK(CLK), .RST_N(RST_N),
    .ADDRESS_TO_L2_VALID_INS(ADDRESS_TO_L2_VALID_INS), .ADDRESS_TO_L2_READY_INS(ADDRESS_TO_L2_READY_INS),
    .ADDRESS_TO_L2_INS(ADDRESS_TO_L2_INS),
    .DATA_FROM_L2_VALID_INS(DATA_FROM_L2_VALID_INS), .DATA_FROM_L2_READY_INS(DATA_FROM_L2_READY_INS),
    .DATA_FROM_L2_INS(DATA_FROM_L2_INS),
    .MEM_RD_VALID(MEM_RD_VALID), .MEM_RD_READY(MEM_RD_READY), .MEM_RD_ADDRESS(MEM_RD_ADDRESS),
    .MEM_DATA_VALID(MEM_DATA_VALID), .MEM_DATA(MEM_DATA),
    .INVALIDATE(INVALIDATE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Memory model: in-order returns, data = 0x1000_0000 + word address.
  typedef struct { logic [29:0] addr; int due; } pend_t;
  pend_t pend[$];
  logic [29:0] rd_log[$];
  int rd_count = 0, rdv_cycles = 0, beats = 0, last_beat_edge = 0, last_due = 0;
  int mem_rdy_pct = 100, lat_min = 2, lat_max = 2;

  always @(negedge CLK) begin
    MEM_DATA_VALID = 0;
    if (!RST_N) begin
      pend.delete();
      MEM_RD_READY = 0;
      last_due = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= edge_cnt + 1) begin
        MEM_DATA_VALID = 1;
        MEM_DATA = 32'h1000_0000 + {2'b00, pend[0].addr};
        void'(pend.pop_front());
        beats++;
        last_beat_edge = edge_cnt + 1;
      end
      MEM_RD_READY = ($urandom_range(99) < mem_rdy_pct);
      if (MEM_RD_VALID) rdv_cycles++;
      if (MEM_RD_VALID && MEM_RD_READY) begin
        automatic int d = edge_cnt + 1 + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        pend.push_back('{MEM_RD_ADDRESS, d});
        last_due = d;
        rd_count++;
        rd_log.push_back(MEM_RD_ADDRESS);
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] exp_line(input logic [29:0] addr);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'h1000_0000 + {2'b00, addr[29:4], 4'(k)};
    return l;
  endfunction

  typedef struct {
    logic [29:0] addr;
    int          hold;       // cycles of DATA_FROM_L2_READY_INS low in RESP
    bit          inv_fill;   // pulse INVALIDATE during the fill
    bit          inv_acc;    // INVALIDATE high on the accept cycle
    bit          stall;      // random memory ready / latency
    int          exp_reads;
  } vec_t;

  task automatic do_req(input vec_t v, input string tn);
    int n, r0, v0, acc_edge, v_edge;
    bit ok, stable;
    logic [511:0] cap;
    n = 0;
    while (!ADDRESS_TO_L2_READY_INS && n < 50) begin @(negedge CLK); n++; end
    if (n >= 50) begin chk({tn, " ready_timeout"}, 0, 1); return; end
    r0 = rd_count; v0 = rdv_cycles; rd_log.delete();
    ADDRESS_TO_L2_VALID_INS = 1; ADDRESS_TO_L2_INS = v.addr; INVALIDATE = v.inv_acc;
    @(posedge CLK); #1;
    acc_edge = edge_cnt;
    ADDRESS_TO_L2_VALID_INS = 0; INVALIDATE = 0;
    n = 0;
    do begin
      @(negedge CLK); n++;
      if (v.inv_fill) INVALIDATE = (n == 3);
    end while (!DATA_FROM_L2_VALID_INS && n < 400);
    INVALIDATE = 0;
    if (!DATA_FROM_L2_VALID_INS) begin chk({tn, " valid_timeout"}, 0, 1); return; end
    v_edge = edge_cnt;
    chk({tn, " latency"}, v_edge, (v.exp_reads == 0) ? acc_edge : last_beat_edge);
    cap = DATA_FROM_L2_INS;
    chk({tn, " line"}, cap, exp_line(v.addr));
    stable = 1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge CLK);
      if (!DATA_FROM_L2_VALID_INS || DATA_FROM_L2_INS !== cap || ADDRESS_TO_L2_READY_INS) stable = 0;
    end
    if (v.hold > 0) chk({tn, " held_stable"}, stable, 1);
    DATA_FROM_L2_READY_INS = 1;
    @(posedge CLK); #1;
    DATA_FROM_L2_READY_INS = 0;
    @(negedge CLK);
    chk({tn, " one_transfer"}, {DATA_FROM_L2_VALID_INS, ADDRESS_TO_L2_READY_INS, BUSY}, 3'b010);
    chk({tn, " reads"}, rd_count - r0, v.exp_reads);
    if (v.exp_reads == 0) chk({tn, " rd_valid_cycles"}, rdv_cycles - v0, 0);
    else begin
      ok = (rd_log.size() == 16);
      foreach (rd_log[i]) if (rd_log[i] !== {v.addr[29:4], 4'(i)}) ok = 0;
      chk({tn, " rd_addr_order"}, ok, 1);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int b0, n;
    vecs = '{
      '{30'h03, 0, 0, 0, 0, 16},  // cold miss, line 0
      '{30'h09, 0, 0, 0, 0, 0},   // hit same line
      '{30'h0F, 5, 0, 0, 0, 0},   // hit with response backpressure
      '{30'h25, 0, 1, 0, 0, 16},  // invalidate during fill of tag 2
      '{30'h20, 0, 0, 0, 0, 16},  // tag 2 not retained -> refetch
      '{30'h2F, 0, 0, 0, 0, 0},   // now retained
      '{30'h13, 2, 0, 0, 0, 16},
      '{30'h55, 0, 0, 0, 1, 16},  // memory stalls
      '{30'h07, 3, 0, 0, 1, 16},
      '{30'h01, 0, 0, 1, 0, 16}   // invalidate on accept forces miss
    };

    repeat (3) @(negedge CLK);
    chk("reset ready", ADDRESS_TO_L2_READY_INS, 1);
    chk("reset outs", {DATA_FROM_L2_VALID_INS, MEM_RD_VALID, BUSY}, 3'b000);
    chk("reset data", DATA_FROM_L2_INS, '0);
    RST_N = 1;
    @(negedge CLK);

    foreach (vecs[i]) begin
      if (vecs[i].stall) begin mem_rdy_pct = 50; lat_min = 1; lat_max = 6; end
      else               begin mem_rdy_pct = 100; lat_min = 2; lat_max = 2; end
      do_req(vecs[i], $sformatf("v%0d", i));
    end
    mem_rdy_pct = 100; lat_min = 2; lat_max = 2;

    // Reset in the middle of a fill of tag 6.
    b0 = beats;
    ADDRESS_TO_L2_VALID_INS = 1; ADDRESS_TO_L2_INS = 30'h63;
    @(posedge CLK); #1;
    ADDRESS_TO_L2_VALID_INS = 0;
    n = 0;
    while (beats - b0 < 7 && n < 100) begin @(negedge CLK); n++; end
    chk("rst beats_seen", beats - b0, 7);
    @(posedge CLK); #2;
    RST_N = 0;
    #1;
    chk("rst ready", ADDRESS_TO_L2_READY_INS, 1);
    chk("rst outs", {DATA_FROM_L2_VALID_INS, MEM_RD_VALID, BUSY}, 3'b000);
    chk("rst data", DATA_FROM_L2_INS, '0);
    repeat (2) @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    do_req('{30'h60, 0, 0, 0, 0, 16}, "post_rst");
    do_req('{30'h6A, 0, 0, 0, 0, 0}, "post_rst_hit");

    chk("protocol_error", dut.protocol_error, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
